// File: rtl/add_board_pkg.sv
// Shared definitions for the 3-bit adder board: clocking defaults, operand width
// and the per-bit debounce state encoding.
package add_board_pkg;

    localparam int BOARD_CLK_HZ     = 50_000_000;
    localparam int DEF_TICK_DIV     = BOARD_CLK_HZ / 1000;
    localparam int DEF_STABLE_TICKS = 20;
    localparam int OPW              = 3;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// Debounce FSM for one synchronised switch bit: a new level is accepted only after
// it has persisted for STABLE_TICKS debounce ticks without reverting.
module debounce_bit
    import add_board_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic s,
    output logic stable,
    output logic chg
);

    localparam int CNTW = $clog2(STABLE_TICKS);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STABLE_TICKS - 1);

    db_state_e       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;
    logic            chg_q, chg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            chg_q    <= chg_d;
        end
    end

    // Any cycle where the input agrees with the stable level cancels a pending change.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        chg_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s != stable_q) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (s == stable_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = s;
                        chg_d    = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stable = stable_q;
    assign chg    = chg_q;

endmodule

// File: rtl/operand_debounce.sv
// Front end of the adder/display path: synchronises the six active-low DIP switches,
// debounces each bit and presents registered operands plus change/update strobes.
module operand_debounce
    import add_board_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*OPW-1:0] sw_n,
    output logic [OPW-1:0]   a,
    output logic [OPW-1:0]   b,
    output logic [2*OPW-1:0] chg,
    output logic             upd
);

    localparam int NBITS = 2 * OPW;
    localparam int TCW   = $clog2(TICK_DIV);
    localparam logic [TCW-1:0] TCNT_LAST = TCW'(TICK_DIV - 1);

    logic [NBITS-1:0] sync1_q, sync2_q;
    logic [NBITS-1:0] s;
    logic [TCW-1:0]   tickCnt_q, tickCnt_d;
    logic             tick;
    logic [NBITS-1:0] stable;
    logic             upd_q;

    // Reset to the released (all-high) level so a held switch is seen as a fresh change.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sw_n;
            sync2_q <= sync1_q;
        end
    end

    assign s = ~sync2_q;

    assign tick      = (tickCnt_q == TCNT_LAST);
    assign tickCnt_d = tick ? '0 : tickCnt_q + TCW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tickCnt_q <= '0;
            upd_q     <= 1'b0;
        end else begin
            tickCnt_q <= tickCnt_d;
            upd_q     <= |chg;
        end
    end

    for (genvar i = 0; i < NBITS; i++) begin : gBit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) uBit (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .s     (s[i]),
            .stable(stable[i]),
            .chg   (chg[i])
        );
    end

    assign a   = stable[OPW-1:0];
    assign b   = stable[NBITS-1:OPW];
    assign upd = upd_q;

endmodule
